// File: rtl/mips_mul_pkg.sv
// mips_mul_pkg: op codes, controller states and default sizes shared by the HI/LO multiply controller
package mips_mul_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int TIMEOUT_DEF = 64;
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MTHI  = 3'd3,
    OP_MTLO  = 3'd4
  } op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIXUP} state_e;
endpackage

// File: rtl/mul_sign_fix.sv
// mul_sign_fix: operand magnitudes (a_abs, b_abs) and conditional two's-complement negate of the product (prod_fix)
module mul_sign_fix
  import mips_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] prod,
  input  logic               neg,
  output logic [WIDTH-1:0]   a_abs,
  output logic [WIDTH-1:0]   b_abs,
  output logic [2*WIDTH-1:0] prod_fix
);
  // abs of the most negative value wraps to itself, which is its correct unsigned magnitude
  assign a_abs = a[WIDTH-1] ? -a : a;
  assign b_abs = b[WIDTH-1] ? -b : b;
  assign prod_fix = neg ? -prod : prod;
endmodule

// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: drives an external sequential multiplier for MULT/MULTU, handles MTHI/MTLO, owns HI/LO; ports: op_* request, busy/done/err status, hi/lo, mul_* multiplier handshake
module mult_hilo_ctrl
  import mips_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [2:0]         op_code,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  output logic               op_ready,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               mul_work,
  output logic [WIDTH-1:0]   mul_lhs,
  output logic [WIDTH-1:0]   mul_rhs,
  input  logic [2*WIDTH-1:0] mul_result,
  input  logic               mul_end
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_e state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, lhs_q, lhs_d, rhs_q, rhs_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, done_q, done_d, err_q, err_d, work_q, work_d;
  logic [WIDTH-1:0] rs_abs, rt_abs;
  logic [2*WIDTH-1:0] prod_fix;
  mul_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .a(rs_val), .b(rt_val), .prod(prod_q), .neg(neg_q),
    .a_abs(rs_abs), .b_abs(rt_abs), .prod_fix(prod_fix)
  );
  always_comb begin
    state_d = state_q;
    hi_d = hi_q;
    lo_d = lo_q;
    lhs_d = lhs_q;
    rhs_d = rhs_q;
    prod_d = prod_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (op_valid) begin
        case (op_e'(op_code))
          OP_MULT: begin
            neg_d = rs_val[WIDTH-1] ^ rt_val[WIDTH-1];
            lhs_d = rs_abs;
            rhs_d = rt_abs;
            state_d = ISSUE;
          end
          OP_MULTU: begin
            neg_d = 1'b0;
            lhs_d = rs_val;
            rhs_d = rt_val;
            state_d = ISSUE;
          end
          OP_MTHI: hi_d = rs_val;
          OP_MTLO: lo_d = rs_val;
          default: ;
        endcase
      end
      // the multiplier's end may still be high from its previous run, so it is not looked at here
      ISSUE: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mul_end) begin
          prod_d = mul_result;
          state_d = FIXUP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d = 1'b1;
          state_d = IDLE;
        end
      end
      FIXUP: begin
        {hi_d, lo_d} = prod_fix;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d = state_q == FIXUP;
    work_d = state_d == ISSUE || state_d == WAIT;
  end
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hi_q <= '0;
      lo_q <= '0;
      lhs_q <= '0;
      rhs_q <= '0;
      prod_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      work_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      lhs_q <= lhs_d;
      rhs_q <= rhs_d;
      prod_q <= prod_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      done_q <= done_d;
      err_q <= err_d;
      work_q <= work_d;
    end
  end
  assign op_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
  assign hi = hi_q;
  assign lo = lo_q;
  assign mul_work = work_q;
  assign mul_lhs = lhs_q;
  assign mul_rhs = rhs_q;
endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb_mult_hilo_ctrl: multiplier model plus scoreboard bench for mult_hilo_ctrl
module tb_mult_hilo_ctrl;
  localparam int W = 32;
  logic Clk = 1'b0;
  logic reset, op_valid, op_ready, busy, done, err, mul_work;
  logic mul_end = 1'b1;
  logic [2:0] op_code;
  logic [W-1:0] rs_val, rt_val, hi, lo, mul_lhs, mul_rhs;
  logic [2*W-1:0] mul_result = '0;
  int n_chk = 0;
  int n_pass = 0;
  int lat = 1;
  int m_cnt = 0;
  logic m_run = 1'b0;
  logic [2*W-1:0] sb[$];
  mult_hilo_ctrl dut (
    .Clk(Clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .op_ready(op_ready), .busy(busy),
    .done(done), .err(err), .hi(hi), .lo(lo), .mul_work(mul_work),
    .mul_lhs(mul_lhs), .mul_rhs(mul_rhs), .mul_result(mul_result), .mul_end(mul_end)
  );
  always #5 Clk = ~Clk;
  // multiplier model: end idles high, drops when work is seen, rises again lat cycles later
  always @(posedge Clk) begin
    if (!mul_work) begin
      m_run <= 1'b0;
      mul_end <= 1'b1;
    end else if (!m_run) begin
      m_run <= 1'b1;
      m_cnt <= 1;
      mul_end <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt >= lat) begin
        mul_end <= 1'b1;
        mul_result <= 64'(mul_lhs) * 64'(mul_rhs);
      end
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  always @(negedge Clk) begin : mon
    logic [2*W-1:0] e;
    if (reset && done) begin
      if (sb.size() == 0) check("done_extra", 1, 0);
      else begin
        e = sb.pop_front();
        check("hilo", {hi, lo}, e);
      end
    end
  end
  task automatic do_mul(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int l, input logic [W-1:0] ea, input logic [W-1:0] eb,
                        input logic [63:0] exp, input logic push, input int en);
    int n = 0;
    int bad = 0;
    lat = l;
    op_valid = 1'b1;
    op_code = code;
    rs_val = a;
    rt_val = b;
    @(negedge Clk);
    op_valid = 1'b0;
    check("lhs", mul_lhs, ea);
    check("rhs", mul_rhs, eb);
    check("work_issue", mul_work, 1);
    if (push) sb.push_back(exp);
    while (!op_ready && n < 200) begin
      if (!busy) bad++;
      @(negedge Clk);
      n++;
    end
    check("busy_held", bad, 0);
    check("latency", n, en);
  endtask
  initial begin
    reset = 1'b0;
    op_valid = 1'b0;
    op_code = '0;
    rs_val = '0;
    rt_val = '0;
    repeat (3) @(negedge Clk);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_flags", {done, err, mul_work, busy, op_ready}, 5'b00001);
    check("rst_ops", {mul_lhs, mul_rhs}, 0);
    reset = 1'b1;
    @(negedge Clk);
    do_mul(3'd2, 32'hFFFFFFFF, 32'h2, 32, 32'hFFFFFFFF, 32'h2, 64'h00000001_FFFFFFFE, 1, 35);
    do_mul(3'd1, 32'hFFFFFFFD, 32'h7, 5, 32'h3, 32'h7, 64'hFFFFFFFF_FFFFFFEB, 1, 8);
    do_mul(3'd1, 32'h80000000, 32'h80000000, 3, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1, 6);
    do_mul(3'd1, 32'h0, 32'hFFFFFFFB, 2, 32'h0, 32'h5, 64'h0, 1, 5);
    do_mul(3'd1, 32'hFFFFFFFE, 32'hFFFFFFFD, 1, 32'h2, 32'h3, 64'h6, 1, 4);
    op_valid = 1'b1;
    op_code = 3'd3;
    rs_val = 32'h1234;
    @(negedge Clk);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_idle", {busy, op_ready}, 2'b01);
    op_code = 3'd4;
    rs_val = 32'h5678;
    @(negedge Clk);
    op_valid = 1'b0;
    check("mtlo_hilo", {hi, lo}, 64'h00001234_00005678);
    check("mtlo_idle", {busy, op_ready, done}, 3'b010);
    check("err_clear", err, 0);
    do_mul(3'd2, 32'h9, 32'h9, 1000, 32'h9, 32'h9, 64'h0, 0, 65);
    check("to_err", err, 1);
    check("to_hilo", {hi, lo}, 64'h00001234_00005678);
    check("to_state", {done, mul_work, op_ready}, 3'b001);
    do_mul(3'd2, 32'h5, 32'h6, 4, 32'h5, 32'h6, 64'd30, 1, 7);
    check("err_sticky", err, 1);
    lat = 1000;
    op_valid = 1'b1;
    op_code = 3'd2;
    rs_val = 32'h3;
    rt_val = 32'h4;
    @(negedge Clk);
    op_valid = 1'b0;
    repeat (5) @(negedge Clk);
    check("wait_work", {busy, mul_work}, 2'b11);
    reset = 1'b0;
    #1;
    check("arst_flags", {mul_work, op_ready, busy, err}, 4'b0100);
    check("arst_hilo", {hi, lo}, 0);
    @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    do_mul(3'd1, 32'h7, 32'hFFFFFFFF, 2, 32'h7, 32'h1, 64'hFFFFFFFF_FFFFFFF9, 1, 5);
    @(negedge Clk);
    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
